// File: rtl/memory_dma_copy_pkg.sv
// Shared definitions for the port-B block-copy engine: FSM state encoding and
// the base of the memory-mapped IO region (switches on read, LEDs on write).
package memory_dma_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  localparam logic [15:0] IO_BASE = 16'hC000;

endpackage

// File: rtl/memory_dma_copy.sv
// Word-serial block-copy engine mastering port B of the dual-port memory/IO block.
// Each word takes three clocks: present source address, capture read data, write it.
module memory_dma_copy
  import memory_dma_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left,
  output logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] in_dataB,
  output logic                  weB,
  input  logic [DATA_WIDTH-1:0] out_dataB
);

  dma_state_e            state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, addr_q;
  logic [ADDR_WIDTH-1:0] src_d, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  busy_q, done_q, we_q;
  logic                  last_word;

  // Pointers are plain modulo-2**ADDR_WIDTH counters; wrap-around is intended.
  assign src_d     = src_q + ADDR_WIDTH'(1);
  assign dst_d     = dst_q + ADDR_WIDTH'(1);
  assign rem_d     = rem_q - LEN_WIDTH'(1);
  assign last_word = (rem_q == LEN_WIDTH'(1));

  // NOTE: every output comes straight from a flop assigned with <=, so all state
  // updates of one edge see the same pre-edge values and no glitches reach port B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            rem_q  <= length;
            busy_q <= 1'b1;
            if (length == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= src_addr;
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_q <= ST_CAP;
        end
        // addrB stays on the source through CAP so the memory's IO-region mux holds.
        ST_CAP: begin
          data_q  <= out_dataB;
          addr_q  <= dst_q;
          we_q    <= 1'b1;
          state_q <= ST_WR;
        end
        ST_WR: begin
          we_q  <= 1'b0;
          src_q <= src_d;
          dst_q <= dst_d;
          rem_q <= rem_d;
          if (last_word) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            addr_q  <= src_d;
            state_q <= ST_RD;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_left = rem_q;
  assign addrB      = addr_q;
  assign in_dataB   = data_q;
  assign weB        = we_q;

endmodule
